// File: rtl/layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : layer_mac_sequencer
// Brief   : Walks neurons and inputs of one fully connected layer, driving the
//           shared MAC datapath, weight ROM address and activation write-back.
// Revision: 1.0 - initial release
// ============================================================================
module layer_mac_sequencer #(
    parameter int L1_IN   = 62,
    parameter int L1_NEU  = 30,
    parameter int L2_IN   = 30,
    parameter int L2_NEU  = 30,
    parameter int L3_IN   = 30,
    parameter int L3_NEU  = 10,
    parameter int MAC_LAT = 2,
    parameter int ADDR_W  = 12,
    parameter int IDX_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        layer_sel,
    output logic [ADDR_W-1:0] w_addr,
    output logic [IDX_W-1:0]  x_idx,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              act_wr,
    output logic [IDX_W-1:0]  act_idx,
    output logic              busy,
    output logic              calculation_done,
    output logic              cfg_err
);

    localparam int c_DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_INIT = c_DRAIN_W'(MAC_LAT - 1);

    localparam logic [ADDR_W-1:0] c_B0 = '0;
    localparam logic [ADDR_W-1:0] c_B1 = ADDR_W'(L1_IN * L1_NEU);
    localparam logic [ADDR_W-1:0] c_B2 = ADDR_W'(L1_IN * L1_NEU + L2_IN * L2_NEU);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_in_last;
    logic [IDX_W-1:0]      r_neu_last;
    logic [IDX_W-1:0]      r_input;
    logic [IDX_W-1:0]      r_neuron;
    logic [ADDR_W-1:0]     r_w_ptr;
    logic [c_DRAIN_W-1:0]  r_drain;

    logic [IDX_W-1:0]      w_in_last;
    logic [IDX_W-1:0]      w_neu_last;
    logic [ADDR_W-1:0]     w_base;

    always_comb begin
        w_in_last  = IDX_W'(L1_IN - 1);
        w_neu_last = IDX_W'(L1_NEU - 1);
        w_base     = c_B0;
        case (layer_sel)
            2'd1: begin
                w_in_last  = IDX_W'(L2_IN - 1);
                w_neu_last = IDX_W'(L2_NEU - 1);
                w_base     = c_B1;
            end
            2'd2: begin
                w_in_last  = IDX_W'(L3_IN - 1);
                w_neu_last = IDX_W'(L3_NEU - 1);
                w_base     = c_B2;
            end
            default: ;
        endcase
    end

    // Outputs are registered alongside the state, so each one reflects the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_in_last        <= '0;
            r_neu_last       <= '0;
            r_input          <= '0;
            r_neuron         <= '0;
            r_w_ptr          <= '0;
            r_drain          <= '0;
            w_addr           <= '0;
            x_idx            <= '0;
            mac_clr          <= 1'b0;
            mac_en           <= 1'b0;
            act_wr           <= 1'b0;
            act_idx          <= '0;
            busy             <= 1'b0;
            calculation_done <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            w_addr           <= '0;
            x_idx            <= '0;
            mac_clr          <= 1'b0;
            mac_en           <= 1'b0;
            act_wr           <= 1'b0;
            act_idx          <= '0;
            calculation_done <= 1'b0;
            cfg_err          <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (layer_sel != 2'd3) begin
                            r_in_last  <= w_in_last;
                            r_neu_last <= w_neu_last;
                            r_input    <= '0;
                            r_neuron   <= '0;
                            r_w_ptr    <= w_base;
                            r_state    <= S_CLEAR;
                            mac_clr    <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state <= S_ACCUM;
                    mac_en  <= 1'b1;
                    x_idx   <= r_input;
                    w_addr  <= r_w_ptr;
                end
                S_ACCUM: begin
                    if (r_input == r_in_last) begin
                        r_input <= '0;
                        r_drain <= c_DRAIN_INIT;
                        r_state <= S_DRAIN;
                        // Hold the pointer on the very last weight so it stays inside the ROM.
                        if (r_neuron != r_neu_last) begin
                            r_w_ptr <= r_w_ptr + 1'b1;
                        end
                    end else begin
                        r_input <= r_input + 1'b1;
                        r_w_ptr <= r_w_ptr + 1'b1;
                        mac_en  <= 1'b1;
                        x_idx   <= r_input + 1'b1;
                        w_addr  <= r_w_ptr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= S_WRITE;
                        act_wr  <= 1'b1;
                        act_idx <= r_neuron;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_neuron == r_neu_last) begin
                        r_state          <= S_DONE;
                        calculation_done <= 1'b1;
                    end else begin
                        r_neuron <= r_neuron + 1'b1;
                        r_state  <= S_CLEAR;
                        mac_clr  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
